// File: rtl/router_ctrl_if.sv
// router_ctrl_if -- bundles the source handshake and the per-destination
// FIFO signals of the router controller.
//   Source side : pkt_valid, data_in -> controller; busy <- controller
//   FIFO side   : fifo_full, fifo_empty, read_enb -> controller;
//                 data_out, write_enb, vld_out, soft_reset <- controller
//   Status      : lfd_state, parity_err <- controller
// Modports: slave = the controller, master = the environment driving it.
interface router_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [7:0] data_out;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic       busy;
  logic [2:0] vld_out;
  logic       parity_err;
  logic [2:0] soft_reset;

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output data_out, write_enb, lfd_state, busy, vld_out, parity_err, soft_reset
  );

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  data_out, write_enb, lfd_state, busy, vld_out, parity_err, soft_reset
  );
endinterface

// File: rtl/router_ctrl.sv
// router_ctrl -- packet router controller. Parses {len[7:2], addr[1:0]}
// headers, forwards header + len payload bytes + parity byte through a
// one-entry hold register into one of three destination FIFOs, drops
// packets addressed to 3, and checks the running XOR parity.
// Ports:
//   clock - rising-edge clock for all state
//   reset - asynchronous active-high reset
//   bus   - router_ctrl_if.slave (source handshake, FIFO strobes/status)
// Configuration macro: ROUTER_CTRL_TIMEOUT_EN adds per-destination read
// timeout counters that pulse soft_reset; without it soft_reset is 0.
module router_ctrl (
  input  logic         clock,
  input  logic         reset,
  router_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    DECODE = 2'd0,
    LOAD   = 2'd1,
    DROP   = 2'd2
  } state_t;

  // Running parity accumulator step.
  function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Selects one destination bit; address 3 has no FIFO and reads as 0.
  function automatic logic bit_sel(input logic [2:0] vec, input logic [1:0] idx);
    case (idx)
      2'd0:    return vec[0];
      2'd1:    return vec[1];
      2'd2:    return vec[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  state_t     state_r, state_nx_s;
  logic       hold_valid_r;
  logic [7:0] hold_data_r;
  logic [1:0] dest_r;
  logic [6:0] count_r;
  logic [7:0] parity_r;
  logic       parity_err_r;
  logic [2:0] soft_reset_s;

  logic       busy_s, accept_s, lfd_s, load_hold_s, flush_s;
  logic [2:0] write_s;
  logic [1:0] hdr_addr_s;
  logic [5:0] hdr_len_s;
  logic       dest_full_s, dest_srst_s, hdr_full_s;

  assign hdr_addr_s  = bus.data_in[1:0];
  assign hdr_len_s   = bus.data_in[7:2];
  assign dest_full_s = bit_sel(bus.fifo_full, dest_r);
  assign dest_srst_s = bit_sel(soft_reset_s, dest_r);
  assign hdr_full_s  = bit_sel(bus.fifo_full, hdr_addr_s);

  // Next-state, handshake and write-strobe decode.
  always_comb begin
    state_nx_s  = state_r;
    busy_s      = 1'b0;
    accept_s    = 1'b0;
    lfd_s       = 1'b0;
    load_hold_s = 1'b0;
    // A soft reset of the current destination abandons the held byte.
    flush_s     = (state_r == LOAD) && dest_srst_s;
    if (hold_valid_r && !dest_full_s && !flush_s) begin
      write_s = one_hot(dest_r);
    end else begin
      write_s = 3'b000;
    end
    case (state_r)
      DECODE: begin
        busy_s   = hold_valid_r | hdr_full_s;
        accept_s = bus.pkt_valid & ~busy_s & ~reset;
        if (accept_s) begin
          load_hold_s = (hdr_addr_s != 2'd3);
          lfd_s       = (hdr_addr_s != 2'd3);
          state_nx_s  = (hdr_addr_s != 2'd3) ? LOAD : DROP;
        end else begin
          state_nx_s = DECODE;
        end
      end
      LOAD: begin
        busy_s      = hold_valid_r & dest_full_s;
        accept_s    = bus.pkt_valid & ~busy_s & ~reset;
        load_hold_s = accept_s & ~flush_s;
        if (accept_s && count_r == 7'd1) begin
          state_nx_s = DECODE;
        end else if (flush_s) begin
          state_nx_s = DROP;
        end else begin
          state_nx_s = LOAD;
        end
      end
      DROP: begin
        accept_s = bus.pkt_valid & ~reset;
        if (accept_s && count_r == 7'd1) begin
          state_nx_s = DECODE;
        end else begin
          state_nx_s = DROP;
        end
      end
      default: begin
        state_nx_s = DECODE;
      end
    endcase
  end

  // State, hold register, byte count and parity tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= DECODE;
      hold_valid_r <= 1'b0;
      hold_data_r  <= 8'd0;
      dest_r       <= 2'd0;
      count_r      <= 7'd0;
      parity_r     <= 8'd0;
      parity_err_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      parity_err_r <= 1'b0;
      if (load_hold_s) begin
        hold_valid_r <= 1'b1;
        hold_data_r  <= bus.data_in;
      end else if (write_s != 3'b000 || flush_s) begin
        hold_valid_r <= 1'b0;
      end
      if (accept_s) begin
        case (state_r)
          DECODE: begin
            count_r  <= {1'b0, hdr_len_s} + 7'd1;
            parity_r <= bus.data_in;
            if (hdr_addr_s != 2'd3) begin
              dest_r <= hdr_addr_s;
            end
          end
          LOAD: begin
            count_r <= count_r - 7'd1;
            if (count_r == 7'd1) begin
              // Parity byte: compare against the XOR of header + payload.
              parity_err_r <= !flush_s && (parity_r != bus.data_in);
              parity_r     <= 8'd0;
            end else begin
              parity_r <= parity_acc(parity_r, bus.data_in);
            end
          end
          DROP: begin
            count_r  <= count_r - 7'd1;
            parity_r <= 8'd0;
          end
          default: begin
            count_r <= 7'd0;
          end
        endcase
      end
    end
  end

`ifdef ROUTER_CTRL_TIMEOUT_EN
  logic [4:0] tmo_cnt_r [3];
  logic [2:0] soft_reset_r;

  // Per-destination timeout: counts cycles a FIFO holds data with no read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        tmo_cnt_r[i] <= 5'd0;
      end
      soft_reset_r <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.read_enb[i] || bus.fifo_empty[i]) begin
          tmo_cnt_r[i]    <= 5'd0;
          soft_reset_r[i] <= 1'b0;
        end else if (tmo_cnt_r[i] == 5'd29) begin
          // This increment reaches 30: pulse and restart.
          tmo_cnt_r[i]    <= 5'd0;
          soft_reset_r[i] <= 1'b1;
        end else begin
          tmo_cnt_r[i]    <= tmo_cnt_r[i] + 5'd1;
          soft_reset_r[i] <= 1'b0;
        end
      end
    end
  end

  assign soft_reset_s = soft_reset_r;
`else
  assign soft_reset_s = 3'b000;
`endif

  assign bus.data_out   = hold_data_r;
  assign bus.write_enb  = write_s;
  assign bus.lfd_state  = lfd_s;
  assign bus.busy       = busy_s & ~reset;
  assign bus.vld_out    = ~bus.fifo_empty;
  assign bus.parity_err = parity_err_r;
  assign bus.soft_reset = soft_reset_s;

endmodule

// File: doc/router_ctrl.md
ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: pkt_valid  in  1  source byte valid on data_in.
REQ-004 SHALL have: data_in  in  8  packet byte; header = {len[7:2], addr[1:0]}.
REQ-005 SHALL have: fifo_full, fifo_empty  in  3  per-destination FIFO status.
REQ-006 SHALL have: read_enb  in  3  per-destination FIFO read strobes.
REQ-007 SHALL have: data_out  out  8  byte to all FIFOs; write_enb  out  3  one-hot FIFO write.
REQ-008 SHALL have: lfd_state  out  1  header marker; busy  out  1  source must hold byte.
REQ-009 SHALL have: vld_out  out  3  (= ~fifo_empty); parity_err  out  1; soft_reset  out  3.

Function
REQ-010 Byte accepted at a rising edge iff pkt_valid=1 and busy=0.
REQ-011 Packet = header + len payload bytes + parity byte (len+2 bytes); len=0 legal.
REQ-012 States: DECODE, LOAD, DROP.
REQ-013 DECODE: busy=1 while hold register valid or (addr!=3 and fifo_full[addr]); otherwise accept header.
REQ-014 Header with addr 0..2: latch dest=addr, load remaining count=len+1, go LOAD; addr=3: load count, go DROP.
REQ-015 lfd_state SHALL be 1 exactly in the cycle a valid-address header is accepted, 0 otherwise.
REQ-016 Accepted non-dropped byte goes to one-entry hold register driving data_out on the next edge.
REQ-017 write_enb[dest] = hold_valid and !fifo_full[dest]; other bits 0; hold clears when written.
REQ-018 Latency: byte accepted at edge N is written at edge N+1 when FIFO not full; FIFO never written while full.
REQ-019 LOAD/DROP: busy = hold_valid and fifo_full[dest] (DROP: busy=0); new byte accepted same edge hold is written.
REQ-020 Count decrements per accepted byte; parity byte accepted with count=1 returns FSM to DECODE.
REQ-021 pkt_valid low mid-packet: no acceptance, state and count held, no timeout on source.
REQ-022 Running XOR over header and payload; at parity acceptance mismatch pulses parity_err one cycle (next cycle); dropped packets never flag.
REQ-023 soft_reset[dest] during LOAD: hold cleared, FSM moves to DROP with remaining count.
REQ-024 data_out holds last value when hold not valid.

Reset
REQ-025 reset SHALL force: state DECODE, hold_valid 0, count 0, parity 0, timeout counters 0.
REQ-026 Outputs in reset: data_out 0, write_enb 0, lfd_state 0, busy 0, parity_err 0, soft_reset 0; vld_out follows fifo_empty.
REQ-027 Reset mid-packet discards the packet; next accepted byte is treated as header.

Configuration
REQ-028 Macro ROUTER_CTRL_TIMEOUT_EN defined: per destination i, 5-bit counter increments while vld_out[i]=1 and read_enb[i]=0, clears on read_enb[i]=1 or fifo_empty[i]=1.
REQ-029 With macro: counter reaching 30 pulses soft_reset[i] one cycle and clears counter.
REQ-030 Without macro: soft_reset SHALL be constant 0 and no counters exist.

Verification
REQ-031 Header 8'h0D (len 3, addr 1), 3 payload, correct parity, FIFOs empty -> write_enb=3'b010 for 5 consecutive cycles, lfd_state one cycle at header, parity_err 0.
REQ-032 Packet len 20 to addr 0, no reads, fifo_full asserted after 16 writes -> busy=1, no write while full, no byte lost after draining.
REQ-033 Header 8'h07 (addr 3, len 1) + 2 bytes -> write_enb stays 0, FSM back to DECODE after 3 accepted bytes.
REQ-034 len 2 packet with wrong parity byte -> parity_err=1 for exactly one cycle after parity acceptance.
REQ-035 TIMEOUT_EN: vld_out[2]=1, read_enb[2]=0 for 30 cycles -> soft_reset[2]=1 one cycle; mid-LOAD to dest 2 -> rest of packet dropped.
REQ-036 reset asserted during payload byte 2 -> outputs reset immediately; next packet header decoded correctly.
